// File: rtl/bus_arb_pkg.sv
// Shared definitions for the split-capable two-master bus arbiter: FSM encoding,
// slave-select constants, default watchdog limit and a split-enable lookup helper.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    M1_OWN = 2'd1,
    M2_OWN = 2'd2
  } arb_state_e;

  localparam int unsigned S1          = 0;
  localparam int unsigned S2          = 1;
  localparam int unsigned S3          = 2;
  localparam int unsigned SEL_INVALID = 3;

  localparam int DEFAULT_TIMEOUT = 255;

  // Split request of the slave addressed by sel; the invalid select never splits.
  function automatic logic split_of(input int unsigned sel, input logic [2:0] en);
    case (sel)
      S1:      return en[0];
      S2:      return en[1];
      S3:      return en[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts owned cycles and flags expiry on the TIMEOUT-th cycle.
module arb_watchdog #(
  parameter int TIMEOUT = bus_arb_pkg::DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of owned cycles already completed.
  assign expired = run && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (run && !expired)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/split_arbiter.sv
// Two-master bus arbiter with single pending split, resume-first policy and grant watchdog.
// Define SPLIT_ARB_ROUND_ROBIN_EN for round-robin contest resolution (default: M1 priority).
module split_arbiter
  import bus_arb_pkg::*;
#(
  parameter int SLAVE_LEN = 2,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m1_request,
  input  logic                 m2_request,
  input  logic [SLAVE_LEN-1:0] m1_slave_sel,
  input  logic [SLAVE_LEN-1:0] m2_slave_sel,
  input  logic                 trans_done,
  input  logic                 s1_split_en,
  input  logic                 s2_split_en,
  input  logic                 s3_split_en,
  output logic                 m1_grant,
  output logic                 m2_grant,
  output logic                 arbiter_busy,
  output logic                 bus_busy,
  output logic                 bus_master_sel,
  output logic [SLAVE_LEN-1:0] bus_slave_sel,
  output logic                 arb_timeout
);

  arb_state_e           state_q, state_d;
  logic [SLAVE_LEN-1:0] sel_q, sel_d;
  logic                 spv_q, spv_d;     // split_valid
  logic                 spm_q, spm_d;     // split_master: 0=M1, 1=M2
  logic [SLAVE_LEN-1:0] sps_q, sps_d;     // split_slave
  logic                 tmo_q, tmo_d;
`ifdef SPLIT_ARB_ROUND_ROBIN_EN
  logic                 rr_q, rr_d;       // 1 = M2 preferred in the next contest
`endif

  logic [2:0] split_en;
  logic       elig1, elig2, pick_m2, owner_req;
  logic       gnt_new, gnt_m2;
  logic       wd_expired;

  assign split_en  = {s3_split_en, s2_split_en, s1_split_en};
  assign owner_req = (state_q == M2_OWN) ? m2_request : m1_request;

  // A parked master, or anyone targeting the parked slave, waits for the resume.
  assign elig1 = m1_request && (m1_slave_sel < SLAVE_LEN'(SEL_INVALID)) &&
                 !(spv_q && (!spm_q || (m1_slave_sel == sps_q)));
  assign elig2 = m2_request && (m2_slave_sel < SLAVE_LEN'(SEL_INVALID)) &&
                 !(spv_q && (spm_q || (m2_slave_sel == sps_q)));

`ifdef SPLIT_ARB_ROUND_ROBIN_EN
  assign pick_m2 = elig2 && (!elig1 || rr_q);
`else
  assign pick_m2 = elig2 && !elig1;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    spv_d   = spv_q;
    spm_d   = spm_q;
    sps_d   = sps_q;
    tmo_d   = 1'b0;
    gnt_new = 1'b0;
    gnt_m2  = 1'b0;
`ifdef SPLIT_ARB_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (spv_q && !split_of(32'(sps_q), split_en)) begin
          gnt_new = 1'b1;
          gnt_m2  = spm_q;
          sel_d   = sps_q;
          spv_d   = 1'b0;
        end else if (elig1 || elig2) begin
          gnt_new = 1'b1;
          gnt_m2  = pick_m2;
          sel_d   = pick_m2 ? m2_slave_sel : m1_slave_sel;
        end
      end
      M1_OWN, M2_OWN: begin
        // trans_done outranks a same-cycle split, so no split is recorded then.
        if (trans_done || !owner_req) begin
          state_d = IDLE;
        end else if (split_of(32'(sel_q), split_en) && !spv_q) begin
          state_d = IDLE;
          spv_d   = 1'b1;
          spm_d   = (state_q == M2_OWN);
          sps_d   = sel_q;
        end else if (wd_expired) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (gnt_new) begin
      state_d = gnt_m2 ? M2_OWN : M1_OWN;
`ifdef SPLIT_ARB_ROUND_ROBIN_EN
      rr_d    = !gnt_m2;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      spv_q   <= 1'b0;
      spm_q   <= 1'b0;
      sps_q   <= '0;
      tmo_q   <= 1'b0;
`ifdef SPLIT_ARB_ROUND_ROBIN_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      spv_q   <= spv_d;
      spm_q   <= spm_d;
      sps_q   <= sps_d;
      tmo_q   <= tmo_d;
`ifdef SPLIT_ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (gnt_new),
    .run     (state_q != IDLE),
    .expired (wd_expired)
  );

  assign m1_grant       = (state_q == M1_OWN);
  assign m2_grant       = (state_q == M2_OWN);
  assign bus_busy       = m1_grant || m2_grant;
  assign bus_master_sel = m2_grant;
  assign bus_slave_sel  = sel_q;
  assign arbiter_busy   = (state_q != IDLE) || spv_q;
  assign arb_timeout    = tmo_q;

endmodule

// File: tb/tb_split_arbiter.sv
// Bench for split_arbiter: directed vector table, multi-cycle corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_split_arbiter;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m1_request = 1'b0, m2_request = 1'b0;
  logic [1:0] m1_slave_sel = '0, m2_slave_sel = '0;
  logic       trans_done = 1'b0;
  logic       s1_split_en = 1'b0, s2_split_en = 1'b0, s3_split_en = 1'b0;
  logic       m1_grant, m2_grant, arbiter_busy, bus_busy, bus_master_sel, arb_timeout;
  logic [1:0] bus_slave_sel;

  int checks = 0;
  int errors = 0;

  split_arbiter #(.SLAVE_LEN(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m1_request(m1_request), .m2_request(m2_request),
    .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
    .trans_done(trans_done),
    .s1_split_en(s1_split_en), .s2_split_en(s2_split_en), .s3_split_en(s3_split_en),
    .m1_grant(m1_grant), .m2_grant(m2_grant), .arbiter_busy(arbiter_busy),
    .bus_busy(bus_busy), .bus_master_sel(bus_master_sel),
    .bus_slave_sel(bus_slave_sel), .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m1r; logic [1:0] m1s;
    logic       m2r; logic [1:0] m2s;
    logic       td;  logic [2:0] sp;
    logic       g1;  logic g2; logic [1:0] bsel; logic ab; logic to;
  } vec_t;

  function automatic vec_t mk(input logic m1r, input logic [1:0] m1s, input logic m2r,
                              input logic [1:0] m2s, input logic td, input logic [2:0] sp,
                              input logic g1, input logic g2, input logic [1:0] bsel,
                              input logic ab, input logic to);
    vec_t v;
    v.m1r = m1r; v.m1s = m1s; v.m2r = m2r; v.m2s = m2s; v.td = td; v.sp = sp;
    v.g1 = g1; v.g2 = g2; v.bsel = bsel; v.ab = ab; v.to = to;
    return v;
  endfunction

  // Expected view: select fields only matter while the bus is owned.
  function automatic logic [7:0] expv(input logic g1, input logic g2, input logic [1:0] bsel,
                                      input logic ab, input logic to);
    logic b;
    b = g1 | g2;
    return {g1, g2, b, b ? g2 : 1'b0, b ? bsel : 2'b00, ab, to};
  endfunction

  function automatic logic [7:0] obs();
    return {m1_grant, m2_grant, bus_busy, bus_busy ? bus_master_sel : 1'b0,
            bus_busy ? bus_slave_sel : 2'b00, arbiter_busy, arb_timeout};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic m1r, input logic [1:0] m1s, input logic m2r,
                       input logic [1:0] m2s, input logic td, input logic [2:0] sp);
    m1_request = m1r; m1_slave_sel = m1s;
    m2_request = m2r; m2_slave_sel = m2s;
    trans_done = td;
    {s3_split_en, s2_split_en, s1_split_en} = sp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the bus, what is parked, how long the grant has run.
  int         m_own;    // 0 none, 1 M1, 2 M2
  logic [1:0] m_sel;
  bit         m_spv;
  int         m_spm;
  logic [1:0] m_sps;
  int         m_held;
  int         m_last;
  bit         m_to;

  function automatic bit splits(input logic [1:0] s);
    logic [2:0] en;
    en = {s3_split_en, s2_split_en, s1_split_en};
    return (s == 2'd3) ? 1'b0 : en[s];
  endfunction

  task automatic model_reset();
    m_own = 0; m_sel = '0; m_spv = 0; m_spm = 1; m_sps = '0; m_held = 0; m_last = 2; m_to = 0;
  endtask

  task automatic model_step();
    bit e1, e2, req;
    int w;
    m_to = 0;
    if (m_own == 0) begin
      if (m_spv && !splits(m_sps)) begin
        m_own = m_spm; m_sel = m_sps; m_spv = 0; m_held = 1; m_last = m_own;
      end else begin
        e1 = m1_request && (m1_slave_sel != 2'd3) && !(m_spv && (m_spm == 1 || m1_slave_sel == m_sps));
        e2 = m2_request && (m2_slave_sel != 2'd3) && !(m_spv && (m_spm == 2 || m2_slave_sel == m_sps));
        w = 0;
`ifdef SPLIT_ARB_ROUND_ROBIN_EN
        if (e1 && e2) w = (m_last == 1) ? 2 : 1;
`else
        if (e1 && e2) w = 1;
`endif
        else if (e1) w = 1;
        else if (e2) w = 2;
        if (w != 0) begin
          m_own = w; m_sel = (w == 1) ? m1_slave_sel : m2_slave_sel; m_held = 1; m_last = w;
        end
      end
    end else begin
      req = (m_own == 1) ? m1_request : m2_request;
      if (trans_done || !req) m_own = 0;
      else if (splits(m_sel) && !m_spv) begin
        m_spv = 1; m_spm = m_own; m_sps = m_sel; m_own = 0;
      end else if (m_held == TMO) begin
        m_own = 0; m_to = 1;
      end else m_held++;
    end
  endtask

  vec_t tbl[16];

  initial begin
    #1000000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    int gcnt, tcnt;
    tbl[0]  = mk(1,1,1,0,0,3'b000, 1,0,1,1,0);
    tbl[1]  = mk(1,1,1,0,1,3'b000, 0,0,0,0,0);
`ifdef SPLIT_ARB_ROUND_ROBIN_EN
    tbl[2]  = mk(1,1,1,0,0,3'b000, 0,1,0,1,0);
`else
    tbl[2]  = mk(1,1,1,0,0,3'b000, 1,0,1,1,0);
`endif
    tbl[3]  = mk(0,0,0,0,1,3'b000, 0,0,0,0,0);
    tbl[4]  = mk(1,0,0,0,0,3'b000, 1,0,0,1,0);
    tbl[5]  = mk(1,0,0,0,1,3'b000, 0,0,0,0,0);
    tbl[6]  = mk(0,0,0,0,0,3'b000, 0,0,0,0,0);
    tbl[7]  = mk(1,2,0,0,0,3'b000, 1,0,2,1,0);
    tbl[8]  = mk(1,2,0,0,0,3'b100, 0,0,0,1,0);
    tbl[9]  = mk(1,2,1,2,0,3'b100, 0,0,0,1,0);
    tbl[10] = mk(1,2,1,0,0,3'b100, 0,1,0,1,0);
    tbl[11] = mk(1,2,1,0,0,3'b101, 0,1,0,1,0);
    tbl[12] = mk(1,2,1,0,1,3'b000, 0,0,0,1,0);
    tbl[13] = mk(1,2,0,0,0,3'b000, 1,0,2,1,0);
    tbl[14] = mk(1,2,0,0,1,3'b000, 0,0,0,0,0);
    tbl[15] = mk(0,0,0,0,0,3'b000, 0,0,0,0,0);

    #3;
    chk("reset state", {24'd0, obs()}, 32'd0);
    #9 rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].m1r, tbl[i].m1s, tbl[i].m2r, tbl[i].m2s, tbl[i].td, tbl[i].sp);
      step();
      chk($sformatf("vector %0d", i), {24'd0, obs()},
          {24'd0, expv(tbl[i].g1, tbl[i].g2, tbl[i].bsel, tbl[i].ab, tbl[i].to)});
    end

    // Watchdog: owner holds the bus without ever finishing.
    drive(1,0,0,0,0,3'b000);
    gcnt = 0; tcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (m1_grant) gcnt++;
      if (arb_timeout) begin
        tcnt++;
        drive(0,0,0,0,0,3'b000);
      end
    end
    chk("timeout grant cycles", gcnt, TMO);
    chk("timeout pulses", tcnt, 1);
    chk("timeout idle after", {24'd0, obs()}, 32'd0);

    // trans_done wins over a same-cycle split.
    drive(1,2,0,0,0,3'b000); step();
    chk("done+split grant", {24'd0, obs()}, {24'd0, expv(1,0,2,1,0)});
    drive(1,2,0,0,1,3'b100); step();
    chk("done+split no split", {24'd0, obs()}, {24'd0, expv(0,0,0,0,0)});
    drive(0,0,0,0,0,3'b000); step();
    chk("done+split no resume", {24'd0, obs()}, {24'd0, expv(0,0,0,0,0)});

    // Reset mid-grant with a split parked.
    drive(1,2,0,0,0,3'b000); step();
    drive(1,2,0,0,0,3'b100); step();
    drive(1,2,1,1,0,3'b100); step();
    chk("pre-reset M2 owns", {24'd0, obs()}, {24'd0, expv(0,1,1,1,0)});
    #2 rst = 1'b0;
    #1 chk("async reset outputs", {24'd0, obs()}, 32'd0);
    drive(0,0,0,0,0,3'b000);
    #2 rst = 1'b1;
    step();
    chk("split discarded by reset", {24'd0, obs()}, 32'd0);

    // Randomized traffic against the model.
    model_reset();
    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(0,9) < 7, 2'($urandom_range(0,3)),
            $urandom_range(0,9) < 7, 2'($urandom_range(0,3)),
            $urandom_range(0,9) == 0,
            {$urandom_range(0,7) == 0, $urandom_range(0,7) == 0, $urandom_range(0,7) == 0});
      model_step();
      step();
      chk($sformatf("random cycle %0d", c), {24'd0, obs()},
          {24'd0, expv(m_own == 1, m_own == 2, m_sel, (m_own != 0) || m_spv, m_to)});
      if (m1_grant && m2_grant) chk("mutual exclusion", 32'd1, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
